// File: rtl/fe_ctrl_pkg.sv
// Shared types and default sizes for the fetch redirect controller.
package fe_ctrl_pkg;
    localparam int XLEN_DEF  = 64;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        REDIR = 2'd2
    } fe_ctrl_state_t;
endpackage

// File: rtl/fe_redirect_ctrl_if.sv
// Decode/execute/memory inputs and fetch-steering outputs of the redirect controller.
interface fe_redirect_ctrl_if
    import fe_ctrl_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             DE_V;
    logic             DE_BR;
    logic             V_DEP_STALL;
    logic             EXE_BR_RESOLVE;
    logic             EXE_BR_TAKEN;
    logic [XLEN-1:0]  EXE_BR_TARGET;
    logic             TRAP_REQ;
    logic [XLEN-1:0]  TRAP_VECTOR;
    logic             OUT_FE_PC_MUX;
    logic [XLEN-1:0]  OUT_FE_Target_Address;
    logic             V_OUT_FE_BR_STALL;
    logic             FLUSH;
    logic [CNT_W-1:0] BR_STALL_CNT;

    modport master (
        output DE_V, DE_BR, V_DEP_STALL, EXE_BR_RESOLVE, EXE_BR_TAKEN,
               EXE_BR_TARGET, TRAP_REQ, TRAP_VECTOR,
        input  OUT_FE_PC_MUX, OUT_FE_Target_Address, V_OUT_FE_BR_STALL,
               FLUSH, BR_STALL_CNT
    );

    modport slave (
        input  DE_V, DE_BR, V_DEP_STALL, EXE_BR_RESOLVE, EXE_BR_TAKEN,
               EXE_BR_TARGET, TRAP_REQ, TRAP_VECTOR,
        output OUT_FE_PC_MUX, OUT_FE_Target_Address, V_OUT_FE_BR_STALL,
               FLUSH, BR_STALL_CNT
    );
endinterface

// File: rtl/fe_redirect_ctrl_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         INC,
    output logic [W-1:0] COUNT
);
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            COUNT <= '0;
        else if (INC && (COUNT != '1))
            COUNT <= COUNT + W'(1);
    end
endmodule

// File: rtl/fe_redirect_ctrl.sv
// Fetch control-flow sequencer: holds fetch behind unresolved branches and
// drives the PC redirect on taken branches and traps until fetch takes it.
module fe_redirect_ctrl
    import fe_ctrl_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               CLK,
    input  logic               RESET_N,
    fe_redirect_ctrl_if.slave  bus
);
    fe_ctrl_state_t  state;
    logic            pc_mux;
    logic            stall_q;
    logic            flush;
    logic [XLEN-1:0] target;
    logic            br_in_de;
    logic            stall;

    assign br_in_de = bus.DE_V && bus.DE_BR;

    // Outside RUN the stall is registered; in RUN it kills the fall-through
    // behind a freshly decoded branch in the same cycle.
    assign stall = stall_q || ((state == RUN) && br_in_de);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= RUN;
            pc_mux  <= 1'b0;
            stall_q <= 1'b0;
            flush   <= 1'b0;
            target  <= '0;
        end else begin
            flush <= 1'b0;
            unique case (state)
                RUN: begin
                    if (bus.TRAP_REQ) begin
                        state   <= REDIR;
                        target  <= bus.TRAP_VECTOR;
                        pc_mux  <= 1'b1;
                        stall_q <= 1'b1;
                        flush   <= 1'b1;
                    end else if (br_in_de && !bus.V_DEP_STALL) begin
                        state   <= WAIT;
                        stall_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.TRAP_REQ) begin
                        state  <= REDIR;
                        target <= bus.TRAP_VECTOR;
                        pc_mux <= 1'b1;
                        flush  <= 1'b1;
                    end else if (bus.EXE_BR_RESOLVE) begin
                        if (bus.EXE_BR_TAKEN) begin
                            state  <= REDIR;
                            target <= bus.EXE_BR_TARGET;
                            pc_mux <= 1'b1;
                            flush  <= 1'b1;
                        end else begin
                            state   <= RUN;
                            stall_q <= 1'b0;
                        end
                    end
                end
                REDIR: begin
                    // A fresh trap replaces the pending target, even in the accept cycle.
                    if (bus.TRAP_REQ) begin
                        target <= bus.TRAP_VECTOR;
                        flush  <= 1'b1;
                    end else if (!bus.V_DEP_STALL) begin
                        state   <= RUN;
                        pc_mux  <= 1'b0;
                        stall_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= RUN;
                    pc_mux  <= 1'b0;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .INC     (stall),
        .COUNT   (bus.BR_STALL_CNT)
    );

    assign bus.OUT_FE_PC_MUX         = pc_mux;
    assign bus.OUT_FE_Target_Address = target;
    assign bus.V_OUT_FE_BR_STALL     = stall;
    assign bus.FLUSH                 = flush;
endmodule
